// File: rtl/mux_rr_arb.sv
// ============================================================================
//  Module   : mux_rr_arb
//  Brief    : N-channel registered multiplexer, fixed-select or round-robin
//             arbitration, per-channel valid/ready and source channel tag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_arb #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [SELW-1:0] c_last_ch = SELW'(NCH - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [SELW-1:0]  r_ptr;

    logic             w_load;
    logic             w_gnt_vld;
    logic [SELW-1:0]  w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_data;
    int               w_dist;
    int               w_best;

    // Reset forces the output stage closed so no grant is issued that cycle.
    assign w_load = !rst && (!r_out_valid || out_ready);

    // Round-robin picks the requester with the smallest distance above r_ptr.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_dist    = 0;
        w_best    = NCH;
        if (!mode) begin
            for (int k = 0; k < NCH; k++) begin
                if (sel == SELW'(k) && in_valid[k]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = SELW'(k);
                end
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (in_valid[k]) begin
                    w_dist = (k >= int'(r_ptr)) ? (k - int'(r_ptr))
                                                : (k + NCH - int'(r_ptr));
                    if (w_dist < w_best) begin
                        w_best    = w_dist;
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = SELW'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        in_ready   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_gnt_idx == SELW'(k)) begin
                w_gnt_data  = in_data[k*WIDTH +: WIDTH];
                in_ready[k] = w_load && w_gnt_vld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_gnt_vld) begin
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt_idx;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_ptr <= (w_gnt_idx == c_last_ch) ? '0 : w_gnt_idx + 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arb.sv
// ============================================================================
//  Module   : tb_mux_rr_arb
//  Brief    : Self-checking bench for mux_rr_arb (NCH=4 main DUT, NCH=3 aux).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic [1:0]   sel;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_ch;
    logic         out_valid;
    logic         out_ready;

    logic         d3_rst;
    logic         d3_mode;
    logic [1:0]   d3_sel;
    logic [23:0]  d3_in_data;
    logic [2:0]   d3_in_valid;
    logic [2:0]   d3_in_ready;
    logic [7:0]   d3_out_data;
    logic [1:0]   d3_out_ch;
    logic         d3_out_valid;
    logic         d3_out_ready;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the output register should hold and the RR origin.
    logic        m_valid;
    logic [31:0] m_data;
    int          m_ch;
    int          m_ptr;

    always #5 clk = ~clk;

    mux_rr_arb #(.WIDTH(32), .NCH(4)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_rr_arb #(.WIDTH(8), .NCH(3)) u_dut3 (
        .clk(clk), .rst(d3_rst), .mode(d3_mode), .sel(d3_sel),
        .in_data(d3_in_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_ch(d3_out_ch), .out_valid(d3_out_valid),
        .out_ready(d3_out_ready)
    );

    // Channel granted this cycle, or -1 when nobody may transfer.
    function automatic int model_grant();
        if (rst || !(!m_valid || out_ready)) return -1;
        if (!mode) return in_valid[sel] ? int'(sel) : -1;
        for (int off = 0; off < 4; off++) begin
            if (in_valid[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int g;
        g = model_grant();
        return (g < 0) ? 4'b0000 : (4'b0001 << g);
    endfunction

    task automatic model_tick();
        int g;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        end else if (!m_valid || out_ready) begin
            g = model_grant();
            if (g >= 0) begin
                m_data  = in_data[g*32 +: 32];
                m_ch    = g;
                m_valid = 1'b1;
                if (mode) m_ptr = (g + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic advance();
        @(negedge clk);
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1; mode = 1'b0; sel = 2'd0;
        in_data = {32'd4, 32'd3, 32'd2, 32'd1};
        #1;
        n_vec++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        advance();
        advance();
        n_vec++;
        if ({out_valid, out_data, out_ch} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%0d ch=%0d want 0/0/0",
                     out_valid, out_data, out_ch);
        end
        rst = 1'b0;
    endtask

    task automatic test_fixed_sweep();
        logic [31:0] vals [4];
        vals = '{32'd2, 32'd5, 32'd8, 32'd15};
        in_data = {vals[3], vals[2], vals[1], vals[0]};
        in_valid = 4'hF; out_ready = 1'b1; mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            n_vec++;
            if (in_ready !== (4'b0001 << s)) begin
                n_err++; $display("FAIL sweep_ready sel=%0d: got %b", s, in_ready);
            end
            advance();
            n_vec++;
            if (out_data !== vals[s] || out_ch !== 2'(s) || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL sweep_out sel=%0d: got d=%0d ch=%0d v=%b want d=%0d ch=%0d v=1",
                         s, out_data, out_ch, out_valid, vals[s], s);
            end
        end
    endtask

    task automatic test_rr_fair();
        in_data = {32'd103, 32'd102, 32'd101, 32'd100};
        in_valid = 4'hF; out_ready = 1'b1; mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_vec++;
            if (in_ready !== (4'b0001 << (i % 4))) begin
                n_err++; $display("FAIL rr_ready i=%0d: got %b want one-hot %0d", i, in_ready, i % 4);
            end
            advance();
            n_vec++;
            if (out_ch !== 2'(i % 4) || out_data !== 32'(100 + i % 4) || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rr_out i=%0d: got ch=%0d d=%0d want ch=%0d d=%0d",
                         i, out_ch, out_data, i % 4, 100 + i % 4);
            end
        end
    endtask

    task automatic test_sparse();
        int exp_ch;
        in_valid = 4'b1010; mode = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_ch = (i % 2 == 0) ? 1 : 3;
            #1;
            n_vec++;
            if (in_ready !== (4'b0001 << exp_ch)) begin
                n_err++; $display("FAIL sparse_ready i=%0d: got %b want ch %0d", i, in_ready, exp_ch);
            end
            advance();
            n_vec++;
            if (out_ch !== 2'(exp_ch)) begin
                n_err++; $display("FAIL sparse_ch i=%0d: got %0d want %0d", i, out_ch, exp_ch);
            end
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {32'd40, 32'd30, 32'd5, 32'd10};
        advance();
        out_ready = 1'b0;
        in_data[63:32] = 32'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (in_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_ready i=%0d: got %b want 0000", i, in_ready);
            end
            advance();
            n_vec++;
            if (out_data !== 32'd5 || out_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_hold i=%0d: got d=%0d v=%b want d=5 v=1", i, out_data, out_valid);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0010) begin
            n_err++; $display("FAIL bp_release_ready: got %b want 0010", in_ready);
        end
        advance();
        n_vec++;
        if (out_data !== 32'd6 || out_valid !== 1'b1 || out_ch !== 2'd1) begin
            n_err++; $display("FAIL bp_release_out: got d=%0d v=%b ch=%0d want 6/1/1", out_data, out_valid, out_ch);
        end
    endtask

    task automatic test_idle();
        in_valid = 4'b0000; out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL idle_ready: got %b want 0000", in_ready);
        end
        advance();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'd6) begin
            n_err++; $display("FAIL idle_out: got v=%b d=%0d want v=0 d=6", out_valid, out_data);
        end
        // Non-power-of-two instance: sel=3 is out of range.
        d3_rst = 1'b0; d3_mode = 1'b0; d3_sel = 2'd3; d3_in_valid = 3'b111;
        d3_out_ready = 1'b1; d3_in_data = {8'd77, 8'd66, 8'd55};
        #1;
        n_vec++;
        if (d3_in_ready !== 3'b000) begin
            n_err++; $display("FAIL oor_ready: got %b want 000", d3_in_ready);
        end
        advance();
        n_vec++;
        if (d3_out_valid !== 1'b0) begin
            n_err++; $display("FAIL oor_out_valid: got %b want 0", d3_out_valid);
        end
        d3_sel = 2'd2;
        advance();
        n_vec++;
        if (d3_out_valid !== 1'b1 || d3_out_data !== 8'd77 || d3_out_ch !== 2'd2) begin
            n_err++; $display("FAIL nch3_sel2: got v=%b d=%0d ch=%0d want 1/77/2", d3_out_valid, d3_out_data, d3_out_ch);
        end
        d3_mode = 1'b1; d3_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            advance();
            n_vec++;
            if (d3_out_ch !== 2'(i % 3)) begin
                n_err++; $display("FAIL nch3_rr_wrap i=%0d: got %0d want %0d", i, d3_out_ch, i % 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        in_data = {32'd13, 32'd12, 32'd11, 32'd10};
        advance();
        out_ready = 1'b0; rst = 1'b1; in_valid = 4'hF;
        #1;
        n_vec++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_ready: got %b want 0000", in_ready);
        end
        advance();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_ch !== 2'd0) begin
            n_err++; $display("FAIL rstmid_out: got v=%b d=%0d ch=%0d want 0/0/0", out_valid, out_data, out_ch);
        end
        rst = 1'b0; out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0001) begin
            n_err++; $display("FAIL rstmid_first_grant: got %b want 0001", in_ready);
        end
        advance();
        n_vec++;
        if (out_ch !== 2'd0 || out_data !== 32'd10) begin
            n_err++; $display("FAIL rstmid_first_out: got ch=%0d d=%0d want 0/10", out_ch, out_data);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_rdy;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = $urandom;
            #1;
            exp_rdy = model_ready();
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++; $display("FAIL rand_ready i=%0d: got %b want %b", i, in_ready, exp_rdy);
            end
            advance();
            n_vec++;
            if (out_valid !== m_valid || out_data !== m_data || out_ch !== 2'(m_ch)) begin
                n_err++;
                $display("FAIL rand_out i=%0d: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                         i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        d3_rst = 1'b1; d3_mode = 1'b0; d3_sel = 2'd0; d3_in_data = '0;
        d3_in_valid = '0; d3_out_ready = 1'b1;
        test_reset();
        test_fixed_sweep();
        test_rr_fair();
        test_sparse();
        test_backpressure();
        test_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_rr_arb.md
# mux_rr_arb

Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshake and two selection modes: fixed select (direct successor of the 4:1 32-bit mux) and round-robin arbitration among requesting channels. It sits between several producer streams and a single consumer, adding one register stage and reporting which channel each output word came from.

## Interface
- WIDTH, 32, data width per channel
- NCH, 4, number of input channels (>= 2)
- SELW, $clog2(NCH), width of channel index
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = fixed select by sel, 1 = round-robin
- sel  in  SELW  channel index used when mode = 0
- in_data  in  NCH*WIDTH  flattened inputs, channel k at bits [k*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel valid
- in_ready  out  NCH  per-channel ready (one-hot or zero)
- out_data  out  WIDTH  registered selected word
- out_ch  out  SELW  channel index of out_data
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts word

## Operation
- Output stage is a single register: load = !out_valid || out_ready.
- Grant (combinational, each cycle):
  - mode 0: grant channel sel if in_valid[sel]; sel >= NCH grants nothing.
  - mode 1: first channel with in_valid set, searching from ptr upward and wrapping at NCH-1 -> 0.
- in_ready[k] = load && grant == k; at most one bit set; all zero when nothing granted.
- Transfer on channel k when in_valid[k] && in_ready[k]: out_data <= in_data[k], out_ch <= k, out_valid <= 1.
- If load and no grant: out_valid <= 0, out_data/out_ch hold.
- If out_valid && !out_ready: register holds; all in_ready = 0.
- Round-robin pointer ptr (SELW bits): on transfer from k in mode 1, ptr <= k+1 mod NCH; unchanged otherwise and unchanged by mode-0 transfers.
- mode/sel changes take effect at the next grant; a held output word is never altered.
- Data-independent: in_data of non-granted channels is ignored.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, in_ready = 0 during reset cycle.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: one word per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready, out_valid, in_valid, mode, sel, ptr; no combinational path from in_data to outputs.
- Simultaneous output accept and new input transfer in the same cycle: both happen (no bubble).
- Reset asserted mid-stream: held word discarded, ptr to 0, in_ready = 0 that cycle; first grant possible the cycle after rst deasserts.
- In mode 1 every continuously requesting channel is granted within NCH transfers (no starvation).

## Test plan
- Fixed select sweep: NCH=4, in = 2,5,8,15, all valid, out_ready=1, mode 0, sel 0..3 each for one cycle -> out_data 2,5,8,15 with out_ch 0..3, each one cycle after sel applied.
- Round-robin fairness: mode 1, all four valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,... and one in_ready bit per cycle.
- Sparse requests: mode 1, only channels 1 and 3 valid -> out_ch alternates 1,3,1,3; channels 0/2 never readied.
- Backpressure: out_ready=0 for 3 cycles while word 5 held -> out_data stays 5, out_valid stays 1, all in_ready 0; on release next word appears following cycle with no duplicate or loss.
- Idle/empty: no in_valid -> out_valid drops to 0 after current word accepted; out_data holds last value; sel = out-of-range (NCH=3, sel=3) -> no grant.
- Reset mid-operation: rst high with out_valid=1, ptr=2 -> next cycle out_valid=0, out_data=0, out_ch=0; first round-robin grant after release goes to channel 0.
